// File: rtl/cube_layer_scanner_if.sv
// Frame-memory read port and latch-stage start/done handshake
// shared between cube_layer_scanner and its neighbours.
interface cube_layer_scanner_if #(
  parameter int FRAME_W = 2
);
  logic               mem_rd_en;
  logic [FRAME_W+5:0] mem_addr;
  logic [7:0]         mem_rd_data;
  logic               latch_start;
  logic [2:0]         latch_idx;
  logic [7:0]         latch_data;
  logic               latch_done;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rd_data,
    output latch_start,
    output latch_idx,
    output latch_data,
    input  latch_done
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rd_data,
    input  latch_start,
    input  latch_idx,
    input  latch_data,
    output latch_done
  );
endinterface

// File: rtl/cube_layer_scanner.sv
// LED cube layer sequencer: frame memory -> 8 latches -> lit layer.
// Optional LATCH_TIMEOUT_EN adds a sticky latch_err on a stalled latch.
module cube_layer_scanner #(
  parameter int FRAME_W        = 2,
  parameter int DWELL_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [FRAME_W-1:0]   frame_sel,
  cube_layer_scanner_if.master bus,
  output logic [7:0]           layer_out,
`ifdef LATCH_TIMEOUT_EN
  output logic                 latch_err,
`endif
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RDWAIT,
    ISSUE,
    WAIT_DONE,
    SHOW
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  state_t             state;
  state_t             state_nx;
  logic [2:0]         layer;
  logic [2:0]         idx;
  logic [FRAME_W-1:0] frame_q;
  logic [15:0]        dwell;
  logic [7:0]         data_q;
  logic [2:0]         lidx_q;
  logic               dwell_end;
  logic               byte_last;
  logic               to_hit;
  logic               err_q;

  assign dwell_end = (dwell == DWELL_LAST);
  assign byte_last = (idx == 3'd7);

`ifdef LATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  assign to_hit = !bus.latch_done &&
                  (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign latch_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != WAIT_DONE) to_cnt <= '0;
      else                    to_cnt <= to_cnt + 1'b1;
      if (state == WAIT_DONE && to_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign err_q          = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (enable && !err_q) state_nx = FETCH;
      FETCH:     state_nx = RDWAIT;
      RDWAIT:    state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.latch_done) state_nx = byte_last ? SHOW : FETCH;
        else if (to_hit)    state_nx = IDLE;
      end
      SHOW:      if (dwell_end) state_nx = enable ? FETCH : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      layer      <= '0;
      idx        <= '0;
      frame_q    <= '0;
      dwell      <= '0;
      data_q     <= '0;
      lidx_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          layer   <= '0;
          idx     <= '0;
          frame_q <= frame_sel;
        end
        RDWAIT: begin
          data_q <= bus.mem_rd_data;
          lidx_q <= idx;
        end
        WAIT_DONE: begin
          if (bus.latch_done) begin
            if (byte_last) dwell <= '0;
            else           idx   <= idx + 3'd1;
          end else if (to_hit) begin
            layer <= '0;
            idx   <= '0;
          end
        end
        SHOW: begin
          dwell <= dwell + 16'd1;
          if (dwell_end) begin
            idx <= '0;
            // frame_sel is only honoured on a frame boundary
            if (layer == 3'd7) begin
              frame_done <= 1'b1;
              layer      <= '0;
              frame_q    <= frame_sel;
            end else begin
              layer <= layer + 3'd1;
            end
            if (!enable) layer <= '0;
          end
        end
        default: ;
      endcase
      if (state_nx == IDLE) data_q <= '0;
    end
  end

  assign bus.mem_rd_en   = (state == FETCH);
  assign bus.mem_addr    = {frame_q, layer, idx};
  assign bus.latch_start = (state == ISSUE);
  assign bus.latch_idx   = lidx_q;
  assign bus.latch_data  = data_q;
  assign layer_out       = (state == SHOW) ? (8'd1 << layer) : 8'h00;

endmodule

// File: tb/tb_cube_layer_scanner.sv
// Directed-plus-random bench for cube_layer_scanner with a
// frame-memory model and a latch-stage responder.
module tb_cube_layer_scanner;
  localparam int FW    = 2;
  localparam int DWELL = 3;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [FW-1:0] frame_sel;
  logic [7:0]    layer_out;
  logic          frame_done;
`ifdef LATCH_TIMEOUT_EN
  logic          latch_err;
`endif

  logic [7:0] mem [256];
  int         n_chk  = 0;
  int         n_pass = 0;
  bit         hang   = 1'b0;
  bit         rnd    = 1'b0;
  bit         pend;
  int         cnt;

  cube_layer_scanner_if #(.FRAME_W(FW)) bus ();

  cube_layer_scanner #(
    .FRAME_W       (FW),
    .DWELL_CYCLES  (DWELL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .frame_sel (frame_sel),
    .bus       (bus),
    .layer_out (layer_out),
`ifdef LATCH_TIMEOUT_EN
    .latch_err (latch_err),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // frame memory: data one cycle after the read strobe
  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

  // latch stage: done after a fixed or random delay, or never
  always @(posedge clk) begin
    bus.latch_done <= 1'b0;
    if (!rst_n) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (bus.latch_start) begin
      pend <= 1'b1;
      cnt  <= rnd ? int'($urandom_range(1, 6)) : 4;
    end else if (pend && !hang) begin
      if (cnt <= 1) begin
        bus.latch_done <= 1'b1;
        pend           <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return bus.mem_rd_en;
      1:       return bus.latch_start;
      2:       return bus.latch_done;
      default: return layer_out != 8'h00;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (!cond(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cond(sel)), 32'd1);
  endtask

  task automatic load_layer(input int f, input int l, input int drop_at);
    logic [7:0] a;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      a = 8'(f * 64 + l * 8 + i);
      wait_for(0, "fetch_seen");
      check("mem_addr", 32'(bus.mem_addr), 32'(a));
      wait_for(1, "start_seen");
      d = mem[a];
      check("latch_idx", 32'(bus.latch_idx), 32'(i));
      check("latch_data", 32'(bus.latch_data), 32'(d));
      if (i == drop_at) enable = 1'b0;
      wait_for(2, "done_seen");
      check("data_hold", 32'(bus.latch_data), 32'(d));
    end
  endtask

  task automatic show_layer(input int l);
    int         n = 0;
    logic [7:0] e;
    e = 8'd1 << l;
    wait_for(3, "show_seen");
    while (layer_out === e && n < DWELL + 4) begin
      n++;
      @(negedge clk);
    end
    check("dwell_len", 32'(n), 32'(DWELL));
    check("layer_off", 32'(layer_out), 32'd0);
    check("frame_done", 32'(frame_done), 32'(l == 7));
  endtask

  task automatic quiet(input int cycles, input string tag);
    int busy = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.latch_start || bus.mem_rd_en || layer_out != 8'h00)
        busy++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_layer"}, 32'(layer_out), 32'd0);
    check({tag, "_rd"}, 32'(bus.mem_rd_en), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_start"}, 32'(bus.latch_start), 32'd0);
    check({tag, "_idx"}, 32'(bus.latch_idx), 32'd0);
    check({tag, "_data"}, 32'(bus.latch_data), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int r;
    int r2;
    rst_n     = 1'b0;
    enable    = 1'b0;
    frame_sel = '0;
    for (int a = 0; a < 256; a++)
      mem[a] = (a < 64) ? 8'(a) : 8'($urandom);

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n  = 1'b1;
    enable = 1'b1;

    // frame 0, frame_sel switched mid-frame at layer 3
    for (int l = 0; l < 8; l++) begin
      if (l == 3) frame_sel = 2'd2;
      load_layer(0, l, -1);
      show_layer(l);
    end

    // frame 2 with random latch timing, enable dropped in layer 5
    rnd = 1'b1;
    for (int l = 0; l < 6; l++) begin
      if (l == 2) frame_sel = 2'($urandom);
      load_layer(2, l, (l == 5) ? 2 : -1);
      show_layer(l);
    end
    check("idle_data", 32'(bus.latch_data), 32'd0);
    quiet(30, "idle_quiet");

    // restart, then reset in the middle of layer 2's dwell
    r         = int'($urandom_range(0, 3));
    frame_sel = 2'(r);
    enable    = 1'b1;
    for (int l = 0; l < 2; l++) begin
      load_layer(r, l, -1);
      show_layer(l);
    end
    load_layer(r, 2, -1);
    wait_for(3, "show2_seen");
    check("show2_layer", 32'(layer_out), 32'h04);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("midreset");
    rst_n     = 1'b1;
    r2        = int'($urandom_range(0, 3));
    frame_sel = 2'(r2);
    load_layer(r2, 0, -1);
    show_layer(0);

`ifdef LATCH_TIMEOUT_EN
    begin
      int n = 0;
      hang = 1'b1;
      wait_for(1, "to_start");
      while (!latch_err && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("to_cycles", 32'(n), 32'(TMO + 1));
      check("to_err", 32'(latch_err), 32'd1);
      check("to_layer", 32'(layer_out), 32'd0);
      quiet(40, "to_quiet");
      check("to_err_sticky", 32'(latch_err), 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
